median_window_3x3: RTL and testbench

Streaming 3x3 neighbourhood generator sitting directly upstream of the median sorting network in the MRELBP median-processing path. It accepts one raster-ordered pixel per cycle and buffers the two previous image rows in line buffers. Each fully interior 3x3 window is presented as nine packed samples, with the bottom-right pixel last, to the compare-exchange network that computes the median. The block has no backpressure, so the downstream sorter must be fully pipelined and accept one window per cycle.

---
 rtl/median_window_3x3.sv | 121 ++++++++++++
 tb/tb_median_window_3x3.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/median_window_3x3.sv
// ============================================================================
// Module   : median_window_3x3
// Brief    : Streaming 3x3 neighbourhood generator feeding the median sorter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module median_window_3x3 #(
    parameter int WIDTH = 8,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    input  logic                 i_sof,
    input  logic [WIDTH-1:0]     i_pixel,
    output logic                 o_valid,
    output logic [9*WIDTH-1:0]   o_win,
    output logic                 o_last
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] C_COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] C_ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] C_COL_MIN  = CW'(2);
    localparam logic [RW-1:0] C_ROW_MIN  = RW'(2);

    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [WIDTH-1:0] win_q [0:2][0:2];
    logic [WIDTH-1:0] win_d [0:2][0:2];
    logic [WIDTH-1:0] lb0_q [0:IMG_W-1];
    logic [WIDTH-1:0] lb1_q [0:IMG_W-1];

    logic [CW-1:0]      w_pos_col;
    logic [RW-1:0]      w_pos_row;
    logic [WIDTH-1:0]   w_lb0_rd;
    logic [WIDTH-1:0]   w_lb1_rd;
    logic               w_emit;
    logic               w_last;
    logic [9*WIDTH-1:0] w_win_flat;

    // A start-of-frame pixel is always treated as (0,0), whatever the counters say.
    always_comb begin
        w_pos_col = i_sof ? '0 : col_q;
        w_pos_row = i_sof ? '0 : row_q;
        w_lb0_rd  = lb0_q[w_pos_col];
        w_lb1_rd  = lb1_q[w_pos_col];
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        win_d = win_q;
        if (i_valid) begin
            if (w_pos_col == C_COL_LAST) begin
                col_d = '0;
                row_d = (w_pos_row == C_ROW_LAST) ? '0 : w_pos_row + RW'(1);
            end else begin
                col_d = w_pos_col + CW'(1);
                row_d = w_pos_row;
            end
            for (int i = 0; i < 3; i++) begin
                win_d[i][0] = win_q[i][1];
                win_d[i][1] = win_q[i][2];
            end
            win_d[0][2] = w_lb0_rd;
            win_d[1][2] = w_lb1_rd;
            win_d[2][2] = i_pixel;
        end
    end

    // Requiring col >= 2 also suppresses windows straddling a row wrap.
    always_comb begin
        w_emit = i_valid && (w_pos_row >= C_ROW_MIN) && (w_pos_col >= C_COL_MIN);
        w_last = w_emit && (w_pos_row == C_ROW_LAST) && (w_pos_col == C_COL_LAST);
        w_win_flat = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w_win_flat[WIDTH*(3*i+j) +: WIDTH] = win_d[i][j];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_win   <= '0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_q[i][j] <= '0;
                end
            end
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            o_valid <= w_emit;
            o_last  <= w_last;
            if (w_emit) begin
                o_win <= w_win_flat;
            end
        end
    end

    // Line buffers carry no reset; every entry is rewritten before it is read into a window.
    always_ff @(posedge i_clk) begin
        if (i_valid) begin
            lb0_q[w_pos_col] <= w_lb1_rd;
            lb1_q[w_pos_col] <= i_pixel;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_median_window_3x3.sv
// ============================================================================
// Module   : tb_median_window_3x3
// Brief    : Directed self-checking bench for median_window_3x3 (4x4 and 5x3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_median_window_3x3;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               a_valid, a_sof, a_ovalid, a_last;
    logic [WIDTH-1:0]   a_pix;
    logic [9*WIDTH-1:0] a_win;
    logic               b_valid, b_sof, b_ovalid, b_last;
    logic [WIDTH-1:0]   b_pix;
    logic [9*WIDTH-1:0] b_win;

    int n_vec = 0;
    int n_err = 0;

    median_window_3x3 #(.WIDTH(WIDTH), .IMG_W(4), .IMG_H(4)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(a_valid), .i_sof(a_sof), .i_pixel(a_pix),
        .o_valid(a_ovalid), .o_win(a_win), .o_last(a_last)
    );

    median_window_3x3 #(.WIDTH(WIDTH), .IMG_W(5), .IMG_H(3)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(b_valid), .i_sof(b_sof), .i_pixel(b_pix),
        .o_valid(b_ovalid), .o_win(b_win), .o_last(b_last)
    );

    // Expected window for a ramp image: element (i,j) = top-left value + i*row_len + j.
    function automatic logic [9*WIDTH-1:0] pack_win(input int tl, input int row_len);
        logic [9*WIDTH-1:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[WIDTH*(3*i+j) +: WIDTH] = WIDTH'(tl + i*row_len + j);
        return w;
    endfunction

    task automatic drive_a(input logic v, input logic sof, input int pix);
        a_valid = v; a_sof = sof; a_pix = WIDTH'(pix);
        @(posedge clk); #1;
    endtask

    task automatic drive_b(input logic v, input logic sof, input int pix);
        b_valid = v; b_sof = sof; b_pix = WIDTH'(pix);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_valid = 0; a_sof = 0; a_pix = '0;
        b_valid = 0; b_sof = 0; b_pix = '0;
        repeat (2) @(posedge clk);
        #1;
        n_vec += 6;
        if (a_ovalid !== 1'b0) begin n_err++; $display("FAIL reset_a_valid: got %b want 0", a_ovalid); end
        if (a_win !== '0)      begin n_err++; $display("FAIL reset_a_win: got %h want 0", a_win); end
        if (a_last !== 1'b0)   begin n_err++; $display("FAIL reset_a_last: got %b want 0", a_last); end
        if (b_ovalid !== 1'b0) begin n_err++; $display("FAIL reset_b_valid: got %b want 0", b_ovalid); end
        if (b_win !== '0)      begin n_err++; $display("FAIL reset_b_win: got %h want 0", b_win); end
        if (b_last !== 1'b0)   begin n_err++; $display("FAIL reset_b_last: got %b want 0", b_last); end
        rst_n = 1'b1;
    endtask

    task automatic test_ramp();
        int pulses = 0;
        for (int k = 0; k < 16; k++) begin
            logic ev;
            drive_a(1'b1, k == 0, k);
            ev = (k % 4 >= 2) && (k / 4 >= 2);
            n_vec++;
            if (a_ovalid !== ev) begin n_err++; $display("FAIL ramp_valid k=%0d: got %b want %b", k, a_ovalid, ev); end
            if (ev) begin
                pulses++;
                n_vec += 2;
                if (a_win !== pack_win(k - 10, 4)) begin n_err++; $display("FAIL ramp_win k=%0d: got %h want %h", k, a_win, pack_win(k - 10, 4)); end
                if (a_last !== (k == 15)) begin n_err++; $display("FAIL ramp_last k=%0d: got %b want %b", k, a_last, k == 15); end
            end
        end
        drive_a(1'b0, 1'b0, 0);
        n_vec += 3;
        if (pulses != 4) begin n_err++; $display("FAIL ramp_count: got %0d want 4", pulses); end
        if (a_ovalid !== 1'b0) begin n_err++; $display("FAIL ramp_gap_valid: got %b want 0", a_ovalid); end
        if (a_last !== 1'b0) begin n_err++; $display("FAIL ramp_gap_last: got %b want 0", a_last); end
    endtask

    task automatic test_gaps();
        logic [9*WIDTH-1:0] hold = pack_win(5, 4);
        int pulses = 0;
        for (int k = 0; k < 16; k++) begin
            logic ev;
            drive_a(1'b1, k == 0, k);
            ev = (k % 4 >= 2) && (k / 4 >= 2);
            n_vec++;
            if (a_ovalid !== ev) begin n_err++; $display("FAIL gap_valid k=%0d: got %b want %b", k, a_ovalid, ev); end
            if (ev) begin
                pulses++;
                hold = pack_win(k - 10, 4);
                n_vec++;
                if (a_win !== hold) begin n_err++; $display("FAIL gap_win k=%0d: got %h want %h", k, a_win, hold); end
            end
            drive_a(1'b0, 1'b0, 0);
            n_vec += 2;
            if (a_ovalid !== 1'b0) begin n_err++; $display("FAIL gap_idle_valid k=%0d: got %b want 0", k, a_ovalid); end
            if (a_win !== hold) begin n_err++; $display("FAIL gap_hold k=%0d: got %h want %h", k, a_win, hold); end
        end
        n_vec++;
        if (pulses != 4) begin n_err++; $display("FAIL gap_count: got %0d want 4", pulses); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        for (int k = 0; k < 32; k++) begin
            int idx = k % 16;
            int base = (k < 16) ? 0 : 100;
            logic ev;
            drive_a(1'b1, k == 0, base + idx);
            ev = (idx % 4 >= 2) && (idx / 4 >= 2);
            n_vec++;
            if (a_ovalid !== ev) begin n_err++; $display("FAIL b2b_valid k=%0d: got %b want %b", k, a_ovalid, ev); end
            if (ev) begin
                pulses++;
                n_vec += 2;
                if (a_win !== pack_win(base + idx - 10, 4)) begin n_err++; $display("FAIL b2b_win k=%0d: got %h want %h", k, a_win, pack_win(base + idx - 10, 4)); end
                if (a_last !== (idx == 15)) begin n_err++; $display("FAIL b2b_last k=%0d: got %b want %b", k, a_last, idx == 15); end
                if (pulses == 5) begin
                    n_vec++;
                    if (a_win !== pack_win(100, 4)) begin n_err++; $display("FAIL b2b_fifth: got %h want %h", a_win, pack_win(100, 4)); end
                end
            end
        end
        a_valid = 0;
        n_vec++;
        if (pulses != 8) begin n_err++; $display("FAIL b2b_count: got %0d want 8", pulses); end
    endtask

    task automatic test_resync();
        int pulses = 0;
        for (int k = 0; k < 7; k++) begin
            drive_a(1'b1, k == 0, k);
            n_vec++;
            if (a_ovalid !== 1'b0) begin n_err++; $display("FAIL resync_pre k=%0d: got %b want 0", k, a_ovalid); end
        end
        for (int idx = 0; idx < 16; idx++) begin
            logic ev;
            drive_a(1'b1, idx == 0, 200 + idx);
            ev = (idx % 4 >= 2) && (idx / 4 >= 2);
            n_vec++;
            if (a_ovalid !== ev) begin n_err++; $display("FAIL resync_valid idx=%0d: got %b want %b", idx, a_ovalid, ev); end
            if (ev) begin
                pulses++;
                n_vec++;
                if (a_win !== pack_win(200 + idx - 10, 4)) begin n_err++; $display("FAIL resync_win idx=%0d: got %h want %h", idx, a_win, pack_win(200 + idx - 10, 4)); end
            end
        end
        a_valid = 0;
        n_vec++;
        if (pulses != 4) begin n_err++; $display("FAIL resync_count: got %0d want 4", pulses); end
    endtask

    task automatic test_sof_on_last();
        for (int k = 0; k < 15; k++) drive_a(1'b1, k == 0, k);
        drive_a(1'b1, 1'b1, 50);
        n_vec += 2;
        if (a_ovalid !== 1'b0) begin n_err++; $display("FAIL soflast_valid: got %b want 0", a_ovalid); end
        if (a_last !== 1'b0) begin n_err++; $display("FAIL soflast_last: got %b want 0", a_last); end
        for (int idx = 1; idx < 16; idx++) begin
            logic ev;
            drive_a(1'b1, 1'b0, 50 + idx);
            ev = (idx % 4 >= 2) && (idx / 4 >= 2);
            n_vec++;
            if (a_ovalid !== ev) begin n_err++; $display("FAIL soflast_nvalid idx=%0d: got %b want %b", idx, a_ovalid, ev); end
            if (ev) begin
                n_vec += 2;
                if (a_win !== pack_win(50 + idx - 10, 4)) begin n_err++; $display("FAIL soflast_win idx=%0d: got %h want %h", idx, a_win, pack_win(50 + idx - 10, 4)); end
                if (a_last !== (idx == 15)) begin n_err++; $display("FAIL soflast_olast idx=%0d: got %b want %b", idx, a_last, idx == 15); end
            end
        end
        a_valid = 0;
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        for (int k = 0; k < 13; k++) drive_a(1'b1, k == 0, k);
        a_valid = 0;
        rst_n = 1'b0;
        #1;
        n_vec += 3;
        if (a_ovalid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b want 0", a_ovalid); end
        if (a_win !== '0) begin n_err++; $display("FAIL rstmid_win: got %h want 0", a_win); end
        if (a_last !== 1'b0) begin n_err++; $display("FAIL rstmid_last: got %b want 0", a_last); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int idx = 0; idx < 16; idx++) begin
            logic ev;
            drive_a(1'b1, idx == 0, 20 + idx);
            ev = (idx % 4 >= 2) && (idx / 4 >= 2);
            n_vec++;
            if (a_ovalid !== ev) begin n_err++; $display("FAIL rstmid_nvalid idx=%0d: got %b want %b", idx, a_ovalid, ev); end
            if (ev) begin
                pulses++;
                n_vec++;
                if (a_win !== pack_win(20 + idx - 10, 4)) begin n_err++; $display("FAIL rstmid_nwin idx=%0d: got %h want %h", idx, a_win, pack_win(20 + idx - 10, 4)); end
            end
        end
        a_valid = 0;
        n_vec++;
        if (pulses != 4) begin n_err++; $display("FAIL rstmid_count: got %0d want 4", pulses); end
    endtask

    task automatic test_5x3();
        int pulses = 0;
        for (int k = 0; k < 15; k++) begin
            logic ev;
            drive_b(1'b1, k == 0, k);
            ev = (k % 5 >= 2) && (k / 5 >= 2);
            n_vec++;
            if (b_ovalid !== ev) begin n_err++; $display("FAIL w5_valid k=%0d: got %b want %b", k, b_ovalid, ev); end
            if (ev) begin
                pulses++;
                n_vec += 2;
                if (b_win !== pack_win(k - 12, 5)) begin n_err++; $display("FAIL w5_win k=%0d: got %h want %h", k, b_win, pack_win(k - 12, 5)); end
                if (b_last !== (k == 14)) begin n_err++; $display("FAIL w5_last k=%0d: got %b want %b", k, b_last, k == 14); end
            end
        end
        drive_b(1'b0, 1'b0, 0);
        n_vec += 2;
        if (pulses != 3) begin n_err++; $display("FAIL w5_count: got %0d want 3", pulses); end
        if (b_win !== pack_win(2, 5)) begin n_err++; $display("FAIL w5_final: got %h want %h", b_win, pack_win(2, 5)); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_gaps();
        test_back_to_back();
        test_resync();
        test_sof_on_last();
        test_reset_mid();
        test_5x3();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
